// File: rtl/keypad_scanner_if.sv
// Keypad-side signal bundle of the 4x4 matrix scanner.
// The master modport is the scanner; the slave modport is the keypad and its consumer.
interface keypad_scanner_if;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_pulse;
    logic       key_held;
    logic       release_pulse;

    modport master (
        input  row_in,
        output col_out,
        output key_code,
        output key_pulse,
        output key_held,
        output release_pulse
    );

    modport slave (
        output row_in,
        input  col_out,
        input  key_code,
        input  key_pulse,
        input  key_held,
        input  release_pulse
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad matrix scanner: rotates one-hot column drive and classifies each full scan.
// A debounced single key produces key_pulse/key_held; a debounced release produces release_pulse.
module keypad_scanner #(
    parameter int SCAN_DIV       = 5000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic              clk,
    input  logic              reset,
    keypad_scanner_if.master  kp
);
    localparam int                DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]        DEB_N    = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {IDLE, PRESS_DEB, HELD, REL_DEB} state_e;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    function automatic logic [1:0] onehot_index(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    logic [3:0]       row_meta_q, row_sync_q;
    logic [DIV_W-1:0] div_cnt_q;
    logic [3:0]       col_q;
    logic [1:0]       acc_cnt_q;
    logic [3:0]       acc_code_q;
    state_e           state_q, state_d;
    logic [3:0]       scan_cnt_q, scan_cnt_d;
    logic [3:0]       cand_q, cand_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_held_q, key_held_d;
    logic             key_pulse_q, key_pulse_d;
    logic             release_pulse_q, release_pulse_d;

    logic             tick_s, scan_done_s, press_s, release_s;
    logic [1:0]       col_idx_s, base_cnt_s, res_cnt_s;
    logic [2:0]       row_pc_s, sum_s;
    logic [3:0]       base_code_s, res_code_s;
    logic             res_none_s, res_single_s;

    // Hit accumulation: count saturates at 2 (MULTI); code is the first single hit of the scan.
    always_comb begin
        tick_s      = (div_cnt_q == DIV_LAST);
        col_idx_s   = onehot_index(col_q);
        row_pc_s    = popcount4(row_sync_q);
        base_cnt_s  = (col_idx_s == 2'd0) ? 2'd0 : acc_cnt_q;
        base_code_s = (col_idx_s == 2'd0) ? 4'd0 : acc_code_q;
        sum_s       = {1'b0, base_cnt_s} + row_pc_s;
        res_cnt_s   = (sum_s >= 3'd2) ? 2'd2 : sum_s[1:0];
        if ((base_cnt_s == 2'd0) && (row_pc_s == 3'd1)) begin
            res_code_s = {col_idx_s, onehot_index(row_sync_q)};
        end else begin
            res_code_s = base_code_s;
        end
        scan_done_s  = tick_s && (col_idx_s == 2'd3);
        res_none_s   = (res_cnt_s == 2'd0);
        res_single_s = (res_cnt_s == 2'd1);
    end

    // Row synchronizer, free-running divider, column rotation and scan accumulator.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta_q <= 4'd0;
            row_sync_q <= 4'd0;
            div_cnt_q  <= '0;
            col_q      <= 4'b0001;
            acc_cnt_q  <= 2'd0;
            acc_code_q <= 4'd0;
        end else begin
            row_meta_q <= kp.row_in;
            row_sync_q <= row_meta_q;
            if (tick_s) begin
                div_cnt_q  <= '0;
                col_q      <= {col_q[2:0], col_q[3]};
                acc_cnt_q  <= res_cnt_s;
                acc_code_q <= res_code_s;
            end else begin
                div_cnt_q  <= div_cnt_q + 1'b1;
            end
        end
    end

    // FSM state, debounce counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            scan_cnt_q      <= 4'd0;
            cand_q          <= 4'd0;
            key_code_q      <= 4'd0;
            key_held_q      <= 1'b0;
            key_pulse_q     <= 1'b0;
            release_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            scan_cnt_q      <= scan_cnt_d;
            cand_q          <= cand_d;
            key_code_q      <= key_code_d;
            key_held_q      <= key_held_d;
            key_pulse_q     <= key_pulse_d;
            release_pulse_q <= release_pulse_d;
        end
    end

    // Next-state logic, evaluated only at full-scan completion.
    always_comb begin
        state_d    = state_q;
        scan_cnt_d = scan_cnt_q;
        cand_d     = cand_q;
        press_s    = 1'b0;
        release_s  = 1'b0;
        if (scan_done_s) begin
            case (state_q)
                IDLE: begin
                    if (res_single_s) begin
                        cand_d     = res_code_s;
                        scan_cnt_d = 4'd1;
                        if (DEB_N == 4'd1) begin
                            state_d = HELD;
                            press_s = 1'b1;
                        end else begin
                            state_d = PRESS_DEB;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                PRESS_DEB: begin
                    if (res_single_s && (res_code_s == cand_q)) begin
                        scan_cnt_d = scan_cnt_q + 4'd1;
                        if ((scan_cnt_q + 4'd1) >= DEB_N) begin
                            state_d = HELD;
                            press_s = 1'b1;
                        end else begin
                            state_d = PRESS_DEB;
                        end
                    end else if (res_single_s) begin
                        cand_d     = res_code_s;
                        scan_cnt_d = 4'd1;
                    end else begin
                        state_d    = IDLE;
                        scan_cnt_d = 4'd0;
                    end
                end
                HELD: begin
                    if (res_none_s) begin
                        scan_cnt_d = 4'd1;
                        if (DEB_N == 4'd1) begin
                            state_d   = IDLE;
                            release_s = 1'b1;
                        end else begin
                            state_d = REL_DEB;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
                REL_DEB: begin
                    if (res_none_s) begin
                        scan_cnt_d = scan_cnt_q + 4'd1;
                        if ((scan_cnt_q + 4'd1) >= DEB_N) begin
                            state_d   = IDLE;
                            release_s = 1'b1;
                        end else begin
                            state_d = REL_DEB;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    scan_cnt_d = 4'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output next values; pulses last one clock since scan completions are far apart.
    always_comb begin
        key_pulse_d     = press_s;
        release_pulse_d = release_s;
        if (press_s) begin
            key_code_d = cand_d;
            key_held_d = 1'b1;
        end else if (release_s) begin
            key_code_d = key_code_q;
            key_held_d = 1'b0;
        end else begin
            key_code_d = key_code_q;
            key_held_d = key_held_q;
        end
    end

    assign kp.col_out       = col_q;
    assign kp.key_code      = key_code_q;
    assign kp.key_held      = key_held_q;
    assign kp.key_pulse     = key_pulse_q;
    assign kp.release_pulse = release_pulse_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad model drives rows from a 16-key set,
// and a run-length debounce model predicts the outcome of every full scan.
module tb_keypad_scanner;
    localparam int SCAN_DIV  = 4;
    localparam int DEB       = 2;
    localparam int SCAN_CLKS = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] keys = 16'h0000;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_seen = 0, rel_seen = 0;
    int pulse_base = 0, rel_base = 0;
    int pulse_exp  = 0, rel_exp  = 0;
    bit prev_strobe = 1'b0;

    bit         m_held;
    logic [3:0] m_code, m_cand;
    int         m_run;

    always #5 clk = ~clk;

    function automatic logic [3:0] rows_for(input logic [15:0] k, input logic [3:0] c);
        case (c)
            4'b0001: return k[3:0];
            4'b0010: return k[7:4];
            4'b0100: return k[11:8];
            4'b1000: return k[15:12];
            default: return 4'h0;
        endcase
    endfunction

    keypad_scanner_if kp();
    assign kp.row_in = rows_for(keys, kp.col_out);

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kp)
    );

    // Strobe monitor: count pulses, flag overlap or back-to-back strobes.
    always @(negedge clk) begin
        if (kp.key_pulse === 1'b1) pulse_seen++;
        if (kp.release_pulse === 1'b1) rel_seen++;
        if (kp.key_pulse === 1'b1 || kp.release_pulse === 1'b1) begin
            n_checks++;
            if ((kp.key_pulse === 1'b1 && kp.release_pulse === 1'b1) || prev_strobe) begin
                n_fail++;
                $display("FAIL strobe_shape: key_pulse=%b release_pulse=%b prev=%b required single isolated strobe",
                         kp.key_pulse, kp.release_pulse, prev_strobe);
            end
        end
        prev_strobe = (kp.key_pulse === 1'b1) || (kp.release_pulse === 1'b1);
    end

    task automatic model_reset();
        m_held = 1'b0; m_code = 4'd0; m_cand = 4'd0; m_run = 0;
        pulse_exp = 0; rel_exp = 0;
        pulse_base = pulse_seen; rel_base = rel_seen;
    endtask

    // Press: DEB consecutive scans showing the same lone key while released.
    // Release: DEB consecutive empty scans while held.
    task automatic model_scan(input logic [15:0] k, output bit press, output bit rel);
        int n;
        logic [3:0] c;
        n = $countones(k);
        c = 4'd0;
        for (int b = 0; b < 16; b++) if (k[b]) c = 4'(b);
        press = 1'b0; rel = 1'b0;
        if (!m_held) begin
            if (n == 1) begin
                if (m_run > 0 && c == m_cand) m_run++;
                else begin m_cand = c; m_run = 1; end
                if (m_run >= DEB) begin
                    press = 1'b1; m_held = 1'b1; m_code = m_cand; m_run = 0; pulse_exp++;
                end
            end else m_run = 0;
        end else begin
            if (n == 0) begin
                m_run++;
                if (m_run >= DEB) begin
                    rel = 1'b1; m_held = 1'b0; m_run = 0; rel_exp++;
                end
            end else m_run = 0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        keys  = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic do_scan(input logic [15:0] k, input string name);
        bit press, rel;
        keys = k;
        repeat (SCAN_CLKS) @(posedge clk);
        #1;
        model_scan(k, press, rel);
        n_checks += 4;
        if (kp.key_pulse !== press) begin
            n_fail++; $display("FAIL %s key_pulse: got %b want %b", name, kp.key_pulse, press);
        end
        if (kp.release_pulse !== rel) begin
            n_fail++; $display("FAIL %s release_pulse: got %b want %b", name, kp.release_pulse, rel);
        end
        if (kp.key_held !== m_held) begin
            n_fail++; $display("FAIL %s key_held: got %b want %b", name, kp.key_held, m_held);
        end
        if (kp.key_code !== m_code) begin
            n_fail++; $display("FAIL %s key_code: got %0d want %0d", name, kp.key_code, m_code);
        end
    endtask

    task automatic check_counts(input string name);
        @(negedge clk);
        #1;
        n_checks += 2;
        if (pulse_seen - pulse_base !== pulse_exp) begin
            n_fail++; $display("FAIL %s pulse_count: got %0d want %0d", name, pulse_seen - pulse_base, pulse_exp);
        end
        if (rel_seen - rel_base !== rel_exp) begin
            n_fail++; $display("FAIL %s release_count: got %0d want %0d", name, rel_seen - rel_base, rel_exp);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        keys  = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (kp.col_out !== 4'b0001 || kp.key_code !== 4'd0 || kp.key_pulse !== 1'b0 ||
            kp.key_held !== 1'b0 || kp.release_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: col=%b code=%0d pulse=%b held=%b rel=%b want 0001/0/0/0/0",
                     kp.col_out, kp.key_code, kp.key_pulse, kp.key_held, kp.release_pulse);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            logic [3:0] want;
            @(posedge clk);
            #1;
            want = (i < 4) ? 4'b0001 : 4'b0010;
            n_checks++;
            if (kp.col_out !== want) begin
                n_fail++; $display("FAIL reset_col_clk%0d: got %b want %b", i, kp.col_out, want);
            end
        end
    endtask

    task automatic test_clean_press();
        apply_reset();
        repeat (2) do_scan(16'h0200, "clean_press");
        repeat (2) do_scan(16'h0200, "clean_hold");
        repeat (3) do_scan(16'h0000, "clean_release");
        check_counts("clean");
    endtask

    task automatic test_bounce();
        apply_reset();
        for (int i = 0; i < 6; i++) do_scan((i % 2 == 0) ? 16'h0200 : 16'h0000, "bounce");
        check_counts("bounce");
    endtask

    task automatic test_ghost();
        apply_reset();
        repeat (2) do_scan(16'h0208, "ghost_multi");
        repeat (2) do_scan(16'h0200, "ghost_single");
        repeat (2) do_scan(16'h0000, "ghost_release");
        check_counts("ghost");
    endtask

    task automatic test_rollover();
        apply_reset();
        repeat (2) do_scan(16'h0200, "roll_press");
        do_scan(16'h0208, "roll_both");
        repeat (2) do_scan(16'h0008, "roll_other");
        repeat (2) do_scan(16'h0000, "roll_release");
        check_counts("rollover");
    endtask

    task automatic test_mid_reset();
        apply_reset();
        repeat (2) do_scan(16'h0200, "midrst_press");
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        keys  = 16'h0000;
        rel_base = rel_seen;
        @(posedge clk);
        #1;
        n_checks++;
        if (kp.key_held !== 1'b0 || kp.release_pulse !== 1'b0 || kp.key_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_abort: held=%b rel=%b pulse=%b want 0/0/0",
                     kp.key_held, kp.release_pulse, kp.key_pulse);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (rel_seen - rel_base !== 0) begin
            n_fail++; $display("FAIL midrst_no_release: got %0d releases want 0", rel_seen - rel_base);
        end
    endtask

    task automatic test_random();
        logic [15:0] k;
        int hold;
        apply_reset();
        for (int s = 0; s < 40; s += hold) begin
            case ($urandom_range(0, 3))
                0:       k = 16'h0000;
                1, 2:    k = 16'h0001 << $urandom_range(0, 15);
                default: k = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            endcase
            hold = $urandom_range(1, 4);
            repeat (hold) do_scan(k, "random");
        end
        repeat (3) do_scan(16'h0000, "random_drain");
        check_counts("random");
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_ghost();
        test_rollover();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use a synchronous, active-high reset.
REQ-002 Parameter SCAN_DIV SHALL default to 5000 and sets the clocks per column slot; legal range 2..2^20.
REQ-003 Parameter DEBOUNCE_SCANS SHALL default to 4 and sets the consecutive identical full scans required; legal range 1..15.
REQ-004 Port clk, input, 1 bit: system clock; all logic SHALL be on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port row_in, input, 4 bits: keypad rows, active-high, asynchronous to clk.
REQ-007 Port col_out, output, 4 bits: one-hot, active-high column drive.
REQ-008 Port key_code, output, 4 bits: code of the debounced key, equal to col_index*4 + row_index.
REQ-009 Port key_pulse, output, 1 bit: one-clock strobe on a debounced press; feeds the game block's keypad_enable input.
REQ-010 Port key_held, output, 1 bit: level that is high while a debounced key is held.
REQ-011 Port release_pulse, output, 1 bit: one-clock strobe on a debounced release.

Function
REQ-012 row_in SHALL pass through a 2-flop synchronizer before any use.
REQ-013 Divider: div_cnt SHALL count 0..SCAN_DIV-1 and wrap; "tick" is defined as div_cnt==SCAN_DIV-1.
REQ-014 On each tick, the synchronized rows SHALL be sampled for the current column, then col_out SHALL rotate 0001->0010->0100->1000->0001.
REQ-015 A full scan SHALL complete at the tick of column 3 (col_out==1000); the scan result SHALL include that column's sample.
REQ-016 Scan result classification:
- NONE: zero asserted row bits across all 4 columns.
- SINGLE(code): exactly one asserted row bit.
- MULTI: two or more asserted row bits; MULTI SHALL be treated as NONE for press detection and as not-NONE for release detection.
REQ-017 FSM states SHALL be IDLE, PRESS_DEB, HELD and REL_DEB; the FSM and the scan counter (4 bits) SHALL update only at full-scan completion.
REQ-018 IDLE transitions:
- SINGLE(c): capture cand=c, scan counter=1, go to PRESS_DEB.
- If DEBOUNCE_SCANS==1: go directly to HELD with the press actions of REQ-020.
REQ-019 PRESS_DEB transitions:
- SINGLE(cand): increment the scan counter.
- SINGLE(other code): recapture cand, scan counter=1.
- NONE or MULTI: return to IDLE.
REQ-020 PRESS_DEB exit: when the scan counter reaches DEBOUNCE_SCANS, go to HELD, load key_code=cand, set key_held=1, and assert key_pulse for exactly the next clock.
REQ-021 HELD transitions:
- Any non-NONE result, including a different key or MULTI: stay in HELD, keep key_code unchanged, produce no new pulse.
- NONE: go to REL_DEB with scan counter=1.
REQ-022 REL_DEB transitions:
- NONE: increment the scan counter.
- Non-NONE: return to HELD.
- Counter reaches DEBOUNCE_SCANS: go to IDLE, clear key_held, assert release_pulse for one clock; key_code SHALL hold its last value.
REQ-023 key_pulse and release_pulse SHALL never both be high in the same clock and SHALL never be high for two consecutive clocks.
REQ-024 Scan rotation and the divider SHALL run continuously regardless of FSM state.

Reset
REQ-025 While reset is high at a clock edge, the block SHALL set col_out=0001, key_code=0, key_pulse=0, key_held=0, release_pulse=0, div_cnt=0, scan counter=0, synchronizer=0 and state=IDLE.
REQ-026 Reset asserted in any state SHALL abort it with no pulse emitted; scanning SHALL restart at column 0 on the first clock after reset deasserts.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=2; one full scan = 16 clocks)
REQ-027 Reset check: assert reset for 2 clocks -> col_out=0001 and all other outputs 0; col_out reaches 0010 exactly 4 clocks after reset deasserts.
REQ-028 Clean press: drive row 1 whenever col_out==0100 (code 9) -> exactly one key_pulse with key_code=9 at the end of the second full scan, key_held=1; release -> release_pulse after 2 NONE scans, key_held=0, key_code remains 9.
REQ-029 Bounce: row alternates present/absent on every scan for 6 scans -> no key_pulse and key_held stays 0.
REQ-030 Ghost: keys 9 and 3 held together -> no pulse; release key 3 -> key_pulse with key_code=9 after 2 scans.
REQ-031 Roll-over: hold 9 until HELD, press 3, then release 9 -> no second key_pulse; after all keys are released for 2 scans -> release_pulse.
REQ-032 Mid-operation reset: assert reset while in HELD -> key_held=0 on the next clock; no release_pulse is produced.
